// File: rtl/byte_packer.sv
// Packs RATIO consecutive DATA_W-bit beats into one little-endian word.
// A last-marked beat closes a partial word early, with zero-filled lanes and keep flags.
module byte_packer #(
  parameter int DATA_W = 8,
  parameter int RATIO  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  output logic                     ready_o,
  output logic [DATA_W*RATIO-1:0]  data_o,
  output logic [RATIO-1:0]         keep_o,
  output logic                     last_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int WORD_W = DATA_W * RATIO;
  localparam int CNT_W  = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0]  keepAcc_q, keepAcc_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [RATIO-1:0]  keep_q, keep_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  logic              inXfer, outXfer, complete;
  logic [WORD_W-1:0] mergedData;
  logic [RATIO-1:0]  mergedKeep;

  // A held word that is not being drained blocks input, even mid-accumulation.
  assign ready_o  = !valid_q || ready_i;
  assign inXfer   = valid_i && ready_o;
  assign outXfer  = valid_q && ready_i;
  assign complete = inXfer && ((cnt_q == LAST_SLOT) || last_i);

  always_comb begin
    mergedData = acc_q;
    mergedKeep = keepAcc_q;
    for (int n = 0; n < RATIO; n++) begin
      if (cnt_q == CNT_W'(n)) begin
        mergedData[n*DATA_W +: DATA_W] = data_i;
        mergedKeep[n]                  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    keepAcc_d = keepAcc_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    valid_d   = valid_q;
    if (complete) begin
      data_d    = mergedData;
      keep_d    = mergedKeep;
      last_d    = last_i;
      valid_d   = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
      keepAcc_d = '0;
    end else begin
      if (inXfer) begin
        acc_d     = mergedData;
        keepAcc_d = mergedKeep;
        cnt_d     = cnt_q + CNT_W'(1);
      end
      if (outXfer) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      keepAcc_q <= '0;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      keepAcc_q <= keepAcc_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: accepted bytes feed a queue-based packet model,
// and a negedge monitor compares every presented word against the expected queue.
module tb_byte_packer;

  localparam int DATA_W = 8;
  localparam int RATIO  = 4;
  localparam int WW     = DATA_W * RATIO;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic [DATA_W-1:0] data_i = '0;
  logic              valid_i = 1'b0;
  logic              last_i = 1'b0;
  logic              ready_i = 1'b1;
  logic              ready_o;
  logic [WW-1:0]     data_o;
  logic [RATIO-1:0]  keep_o;
  logic              last_o;
  logic              valid_o;

  typedef struct {
    logic [WW-1:0]    data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  word_t             expQ[$];
  logic [DATA_W-1:0] pend[$];
  int                errors = 0;
  int                checks = 0;
  bit                doneRand = 0;

  byte_packer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .keep_o(keep_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Packet-level reference: collect bytes, emit a word when full or when last arrives.
  function automatic void modelAccept(logic [DATA_W-1:0] b, logic l);
    word_t w;
    pend.push_back(b);
    if (pend.size() == RATIO || l) begin
      w.data = '0;
      foreach (pend[n]) w.data = w.data | (WW'(pend[n]) << (n * DATA_W));
      w.keep = RATIO'((1 << pend.size()) - 1);
      w.last = l;
      expQ.push_back(w);
      pend.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      expQ.delete();
      pend.delete();
      checkOutput("reset_valid", valid_o, 0);
      checkOutput("reset_data", data_o, 0);
      checkOutput("reset_keep", keep_o, 0);
      checkOutput("reset_last", last_o, 0);
    end else begin
      checkOutput("ready_o", ready_o, !valid_o || ready_i);
      checkOutput("valid_o", valid_o, expQ.size() > 0);
      if (valid_o && expQ.size() > 0) begin
        checkOutput("data_o", data_o, expQ[0].data);
        checkOutput("keep_o", keep_o, expQ[0].keep);
        checkOutput("last_o", last_o, expQ[0].last);
        if (ready_i) void'(expQ.pop_front());
      end
      if (valid_i && ready_o) modelAccept(data_i, last_i);
    end
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] b, input logic l);
    bit acc = 0;
    valid_i = 1'b1;
    data_i  = b;
    last_i  = l;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: byte %h not accepted within 100 cycles", b);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    $display("[TB] full word");
    applyStimulus(8'h11, 0); applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0); applyStimulus(8'h44, 0);
    idle(3);

    $display("[TB] partial words");
    applyStimulus(8'hAA, 0); applyStimulus(8'hBB, 1);
    applyStimulus(8'h01, 1);
    idle(3);

    $display("[TB] backpressure");
    ready_i = 1'b0;
    fork
      for (int b = 1; b <= 8; b++) applyStimulus(DATA_W'(b), 0);
      begin
        repeat (8) begin @(posedge clk); #1; end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        ready_i = 1'b1;
      end
    join
    idle(3);

    $display("[TB] back-to-back");
    ready_i = 1'b1;
    for (int b = 1; b <= 8; b++) applyStimulus(DATA_W'(b), 0);
    idle(3);

    $display("[TB] reset mid-word");
    applyStimulus(8'hDE, 0); applyStimulus(8'hAD, 0);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    for (int b = 1; b <= 4; b++) applyStimulus(DATA_W'(b), 0);
    idle(3);

    $display("[TB] async reset while word held");
    ready_i = 1'b0;
    applyStimulus(8'h01, 0); applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0); applyStimulus(8'h04, 1);
    checkOutput("held_valid", valid_o, 1);
    checkOutput("held_last", last_o, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_valid", valid_o, 0);
    checkOutput("async_data", data_o, 0);
    idle(2);
    rstn = 1'b1;
    ready_i = 1'b1;
    idle(2);

    $display("[TB] random traffic");
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          applyStimulus(DATA_W'($urandom), $urandom_range(0, 5) == 0);
        end
        doneRand = 1;
      end
      while (!doneRand) begin
        @(posedge clk); #1;
        ready_i = ($urandom_range(0, 3) != 0);
      end
    join
    ready_i = 1'b1;
    idle(10);
    checkOutput("drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Downstream consumer of the 8-bit ready/valid pipeline stage.
- Accepts a byte stream on a valid/ready slave port and packs RATIO consecutive bytes into one wide word.
- Presents each packed word on a registered valid/ready master port, with per-byte keep flags and a last flag.
- A last-marked input byte flushes a partial word.

Parameters:
DATA_W  8  width of one input beat (bits)
RATIO   4  input beats per output word; legal range 2..16; output width = DATA_W*RATIO

Ports:
clk      input   1               rising-edge clock
rstn     input   1               asynchronous active-low reset
data_i   input   DATA_W          input byte
valid_i  input   1               input byte valid
last_i   input   1               input byte is final of its packet; qualified by valid_i
ready_o  output  1               block can accept a byte this cycle
data_o   output  DATA_W*RATIO    packed word
keep_o   output  RATIO           per-beat valid flags for data_o
last_o   output  1               word ends a packet
valid_o  output  1               output word valid
ready_i  input   1               downstream accepts word

Behaviour:
- Reset (rstn low, async assert, sync release):
  - valid_o=0, data_o=0, keep_o=0, last_o=0.
  - Internal beat counter cnt=0; accumulator and keep accumulator cleared.
  - Any partial word is discarded.
- Handshakes:
  - Input transfer when valid_i && ready_o at a rising edge.
  - Output transfer when valid_o && ready_i at a rising edge.
- ready_o = !valid_o || ready_i (combinational from ready_i).
  - Stalls input whenever a word is held and not being drained, even mid-accumulation.
- Packing order: little-endian. The n-th accepted byte of a word (n=0..RATIO-1) lands in bits [n*DATA_W +: DATA_W] and sets keep bit n.
- Word completion occurs on an input transfer with cnt==RATIO-1 or last_i=1. On that edge:
  - data_o gets the accumulator with the current byte merged in.
  - keep_o gets the keep accumulator merged with bit cnt.
  - last_o gets last_i; valid_o is set to 1.
  - cnt, accumulator and keep accumulator return to 0.
  - Latency: word visible on valid_o the cycle after its completing byte is accepted.
- Non-completing input transfer: byte is written to slot cnt and cnt increments. Outputs are unchanged except that valid_o clears if an output transfer occurs on the same edge.
- Partial words (last_i before slot RATIO-1):
  - Unused byte lanes of data_o are 0; corresponding keep_o bits are 0.
  - The keep_o pattern is always contiguous from bit 0.
- Output hold: while valid_o && !ready_i, data_o/keep_o/last_o/valid_o hold stable.
- Simultaneous events: an output transfer and a completing input transfer on the same edge replace the old word with the new one. valid_o stays 1; no bubble.
- Output transfer with no completing input: valid_o=0 next cycle; data_o may keep its stale value.
- valid_i with ready_o=0: byte not consumed; the source must hold data_i/last_i stable. The block takes no action.
- last_i while valid_i=0 is ignored.
- No internal error states; no overflow is possible, since cnt never exceeds RATIO-1.
- Throughput: one byte per cycle sustained while ready_i=1; one word per RATIO cycles.

Test Plan:
- Reset, ready_i=1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, last_i=0 -> one cycle after 0x44: valid_o=1 for one cycle, data_o=0x44332211, keep_o=4'hF, last_o=0; ready_o stays 1 throughout.
- Bytes 0xAA, 0xBB with last_i=1 on 0xBB -> data_o=0x0000BBAA, keep_o=4'h3, last_o=1. A following 0x01 with last_i=1 -> data_o=0x00000001, keep_o=4'h1, last_o=1.
- ready_i=0, 8 bytes 0x01..0x08 offered continuously ->
  - Word 0x04030201 is held stable.
  - ready_o=0 from the cycle after 0x04 is accepted; bytes 0x05..0x08 wait.
  - Raise ready_i for 1 cycle -> first word transfers; packing resumes.
  - Second word 0x08070605 appears 4 accepted beats later.
- ready_i=1, continuous 8 bytes -> back-to-back words 0x04030201 then 0x08070605 with valid_o high on consecutive completing cycles and no stall.
- Accept 0xDE, 0xAD, pulse rstn low for 2 cycles mid-word, then send 0x01..0x04 -> all outputs 0 during reset; single word 0x04030201, keep_o=4'hF (stale bytes discarded).
- 4th byte with last_i=1 -> data_o full, keep_o=4'hF, last_o=1. Assert rstn low while valid_o=1 -> valid_o drops to 0 asynchronously.
